// File: rtl/bus_cycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// bus_cycle_pkg : cycle/state encodings, status constants and helpers for
// bus_cycle_ctrl.  Rev 1.0
// ============================================================================
package bus_cycle_pkg;

  typedef enum logic [2:0] {
    CYC_OPFETCH = 3'd0,
    CYC_MEMRD   = 3'd1,
    CYC_MEMWR   = 3'd2,
    CYC_IORD    = 3'd3,
    CYC_IOWR    = 3'd4
  } cyc_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5
`ifdef BUS_HOLD_EN
    ,
    ST_HOLD = 3'd6
`endif
  } bus_state_e;

  // {io_m, s1, s0}
  localparam logic [2:0] STATUS_IDLE    = 3'b000;
  localparam logic [2:0] STATUS_OPFETCH = 3'b011;
  localparam logic [2:0] STATUS_MEMRD   = 3'b010;
  localparam logic [2:0] STATUS_MEMWR   = 3'b001;
  localparam logic [2:0] STATUS_IORD    = 3'b110;
  localparam logic [2:0] STATUS_IOWR    = 3'b101;

  function automatic logic is_read(input cyc_type_e t);
    return (t == CYC_OPFETCH) || (t == CYC_MEMRD) || (t == CYC_IORD);
  endfunction

  function automatic logic is_io(input cyc_type_e t);
    return (t == CYC_IORD) || (t == CYC_IOWR);
  endfunction

  function automatic logic [2:0] status_of(input cyc_type_e t);
    logic [2:0] s;
    case (t)
      CYC_OPFETCH: s = STATUS_OPFETCH;
      CYC_MEMRD:   s = STATUS_MEMRD;
      CYC_MEMWR:   s = STATUS_MEMWR;
      CYC_IORD:    s = STATUS_IORD;
      CYC_IOWR:    s = STATUS_IOWR;
      default:     s = STATUS_IDLE;
    endcase
    return s;
  endfunction

endpackage : bus_cycle_pkg
`default_nettype wire

// File: rtl/bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// bus_cycle_ctrl : 8085-style T1/T2/TW/T3/T4 machine-cycle sequencer driving
// the multiplexed external bus. Optional HOLD/HLDA under BUS_HOLD_EN. Rev 1.0
// ============================================================================
module bus_cycle_ctrl
  import bus_cycle_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int WCNT_W   = 4
) (
  input  logic        phi1,
  input  logic        rst,
  input  logic        cyc_start,
  input  logic [2:0]  cyc_type,
  input  logic [15:0] cyc_addr,
  input  logic [7:0]  cyc_wdata,
  output logic        cyc_rdy,
  output logic        cyc_done,
  output logic        cyc_timeout,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic [7:0]  a_hi,
  output logic        ale,
  output logic        rd_n,
  output logic        wr_n,
  output logic        io_m,
  output logic        s1,
  output logic        s0,
  input  logic        ready
`ifdef BUS_HOLD_EN
  ,
  input  logic        hold,
  output logic        hlda,
  output logic        bus_oe
`endif
);

  localparam logic [WCNT_W-1:0] c_wcnt_one = WCNT_W'(1);
  localparam logic [WCNT_W-1:0] c_wcnt_max = WCNT_W'(MAX_WAIT);

  bus_state_e        r_state;
  bus_state_e        w_state_nxt;
  bus_state_e        w_cycle_nxt;
  cyc_type_e         r_type;
  logic [15:0]       r_addr;
  logic [7:0]        r_wdata;
  logic [WCNT_W-1:0] r_wcnt;
  logic              r_tmo;
  logic              w_take_hold;
  logic              w_accept;
  logic              w_wait_limit;
  logic              w_strobe;

`ifdef BUS_HOLD_EN
  assign w_take_hold = hold && cyc_rdy;
`else
  assign w_take_hold = 1'b0;
`endif

  assign w_accept     = cyc_start && cyc_rdy && (cyc_type <= 3'd4) && !w_take_hold;
  assign w_wait_limit = (MAX_WAIT != 0) && ((r_wcnt + c_wcnt_one) == c_wcnt_max);

  // Destination from any state where a new request may be taken.
  always_comb begin
    w_cycle_nxt = ST_IDLE;
    if (w_accept) begin
      w_cycle_nxt = ST_T1;
    end
`ifdef BUS_HOLD_EN
    if (w_take_hold) begin
      w_cycle_nxt = ST_HOLD;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_cycle_nxt;
      ST_T1:   w_state_nxt = ST_T2;
      ST_T2:   w_state_nxt = ready ? ST_T3 : ST_TW;
      ST_TW: begin
        if (ready || w_wait_limit) begin
          w_state_nxt = ST_T3;
        end
      end
      ST_T3:   w_state_nxt = (r_type == CYC_OPFETCH) ? ST_T4 : w_cycle_nxt;
      ST_T4:   w_state_nxt = w_cycle_nxt;
`ifdef BUS_HOLD_EN
      ST_HOLD: w_state_nxt = hold ? ST_HOLD : ST_IDLE;
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge phi1) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_type      <= CYC_OPFETCH;
      r_addr      <= 16'h0000;
      r_wdata     <= 8'h00;
      r_wcnt      <= '0;
      r_tmo       <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      cyc_done    <= 1'b0;
      cyc_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      rdata_valid <= 1'b0;
      cyc_done    <= 1'b0;
      cyc_timeout <= 1'b0;

      if (w_accept) begin
        r_type  <= cyc_type_e'(cyc_type);
        r_addr  <= cyc_addr;
        r_wdata <= cyc_wdata;
      end

      if (w_state_nxt == ST_T1) begin
        r_wcnt <= '0;
        r_tmo  <= 1'b0;
      end else if (r_state == ST_TW) begin
        r_wcnt <= r_wcnt + c_wcnt_one;
        if (!ready && w_wait_limit) begin
          r_tmo <= 1'b1;
        end
      end

      // Completion for non-fetch cycles is reported from T3; fetches wait for T4.
      if (r_state == ST_T3) begin
        if (is_read(r_type)) begin
          rdata       <= ad_in;
          rdata_valid <= 1'b1;
        end
        if (r_type != CYC_OPFETCH) begin
          cyc_done    <= 1'b1;
          cyc_timeout <= r_tmo;
        end
      end

      if (r_state == ST_T4) begin
        cyc_done    <= 1'b1;
        cyc_timeout <= r_tmo;
      end
    end
  end

  assign w_strobe = (r_state == ST_T2) || (r_state == ST_TW) || (r_state == ST_T3);

  always_comb begin
    ale            = 1'b0;
    rd_n           = 1'b1;
    wr_n           = 1'b1;
    ad_oe          = 1'b0;
    ad_out         = 8'h00;
    cyc_rdy        = 1'b0;
    {io_m, s1, s0} = STATUS_IDLE;
    // I/O ports are 8 bits wide and appear on both address halves.
    a_hi           = is_io(r_type) ? r_addr[7:0] : r_addr[15:8];
`ifdef BUS_HOLD_EN
    hlda           = 1'b0;
    bus_oe         = 1'b1;
`endif
    case (r_state)
      ST_IDLE: cyc_rdy = 1'b1;
      ST_T1: begin
        ale            = 1'b1;
        ad_oe          = 1'b1;
        ad_out         = r_addr[7:0];
        {io_m, s1, s0} = status_of(r_type);
      end
      ST_T2, ST_TW, ST_T3: begin
        {io_m, s1, s0} = status_of(r_type);
        if (is_read(r_type)) begin
          rd_n = 1'b0;
        end else begin
          wr_n   = 1'b0;
          ad_oe  = 1'b1;
          ad_out = r_wdata;
        end
        if (r_state == ST_T3) begin
          cyc_rdy = (r_type != CYC_OPFETCH);
        end
      end
      ST_T4: begin
        {io_m, s1, s0} = status_of(r_type);
        cyc_rdy        = 1'b1;
      end
`ifdef BUS_HOLD_EN
      ST_HOLD: begin
        hlda   = 1'b1;
        bus_oe = 1'b0;
      end
`endif
      default: cyc_rdy = 1'b0;
    endcase
  end

  // Only referenced while strobes are active; kept as a named decode for readability.
  logic w_unused;
  assign w_unused = w_strobe;

endmodule : bus_cycle_ctrl
`default_nettype wire

// File: tb/tb_bus_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// tb_bus_cycle_ctrl : randomized self-checking bench for bus_cycle_ctrl.
// Rev 1.0
// ============================================================================
module tb_bus_cycle_ctrl;

  localparam int MAXW = 3;
  localparam int PH_IDLE = 0, PH_T1 = 1, PH_T2 = 2, PH_TW = 3, PH_T3 = 4, PH_T4 = 5;

  logic        phi1 = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_start = 1'b0;
  logic [2:0]  cyc_type = 3'd0;
  logic [15:0] cyc_addr = 16'h0;
  logic [7:0]  cyc_wdata = 8'h0;
  logic        cyc_rdy, cyc_done, cyc_timeout, rdata_valid;
  logic [7:0]  rdata, ad_out, a_hi;
  logic        ad_oe, ale, rd_n, wr_n, io_m, s1, s0;
  logic [7:0]  ad_in = 8'h0;
  logic        ready = 1'b1;
`ifdef BUS_HOLD_EN
  logic        hold = 1'b0;
  logic        hlda, bus_oe;
`endif

  always #5 phi1 = ~phi1;

  bus_cycle_ctrl #(.MAX_WAIT(MAXW), .WCNT_W(4)) dut (
    .phi1(phi1), .rst(rst), .cyc_start(cyc_start), .cyc_type(cyc_type),
    .cyc_addr(cyc_addr), .cyc_wdata(cyc_wdata), .cyc_rdy(cyc_rdy),
    .cyc_done(cyc_done), .cyc_timeout(cyc_timeout), .rdata(rdata),
    .rdata_valid(rdata_valid), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .a_hi(a_hi), .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .io_m(io_m), .s1(s1),
    .s0(s0), .ready(ready)
`ifdef BUS_HOLD_EN
    , .hold(hold), .hlda(hlda), .bus_oe(bus_oe)
`endif
  );

  int total = 0;
  int bad = 0;

  // Pulses owed in the next sampled cycle, and the architecturally visible rdata.
  bit         p_done = 0, p_rv = 0, p_to = 0;
  logic [7:0] exp_rdata = 8'h00;
  logic [7:0] exp_ahi = 8'h00;

  function automatic logic [2:0] status_of(input int t);
    case (t)
      0: return 3'b011;
      1: return 3'b010;
      2: return 3'b001;
      3: return 3'b110;
      4: return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit t_read(input int t);
    return (t == 0) || (t == 1) || (t == 3);
  endfunction

  function automatic bit t_io(input int t);
    return (t == 3) || (t == 4);
  endfunction

  // {ale, rd_n, wr_n, ad_oe, io_m, s1, s0, cyc_rdy, cyc_done, rdata_valid, cyc_timeout, a_hi, rdata}
  function automatic logic [26:0] expect_vec(input int ph, input int t, input logic [7:0] ahi);
    bit         strobe;
    logic [2:0] st;
    bit         rdy;
    strobe = (ph == PH_T2) || (ph == PH_TW) || (ph == PH_T3);
    st     = (ph == PH_IDLE) ? 3'b000 : status_of(t);
    rdy    = (ph == PH_IDLE) || (ph == PH_T4) || ((ph == PH_T3) && (t != 0));
    return {ph == PH_T1, !(strobe && t_read(t)), !(strobe && !t_read(t)),
            (ph == PH_T1) || (strobe && !t_read(t)), st, rdy,
            p_done, p_rv, p_to, ahi, exp_rdata};
  endfunction

  function automatic logic [26:0] obs_vec();
    return {ale, rd_n, wr_n, ad_oe, io_m, s1, s0, cyc_rdy, cyc_done, rdata_valid,
            cyc_timeout, a_hi, rdata};
  endfunction

  task automatic issue(input int t, input logic [15:0] a, input logic [7:0] w);
    cyc_start = 1'b1;
    cyc_type  = 3'(t);
    cyc_addr  = a;
    cyc_wdata = w;
  endtask

  // Plays one machine cycle: the request must already be driven (cyc_start=1).
  // z = number of consecutive ready=0 samples starting at the end of T2.
  task automatic run_txn(input int t, input logic [15:0] a, input logic [7:0] w,
                         input logic [7:0] din, input int z, input bit chain,
                         input int nt, input logic [15:0] na, input logic [7:0] nw);
    int          nwait;
    bit          to;
    int          seq[$];
    int          ph;
    int          tws;
    logic [26:0] e, o;
    nwait = (z > MAXW) ? MAXW : z;
    to    = (z > MAXW);
    tws   = 0;
    seq.push_back(PH_T1);
    seq.push_back(PH_T2);
    for (int k = 0; k < nwait; k++) seq.push_back(PH_TW);
    seq.push_back(PH_T3);
    if (t == 0) seq.push_back(PH_T4);
    exp_ahi = t_io(t) ? a[7:0] : a[15:8];
    for (int i = 0; i < seq.size(); i++) begin
      @(negedge phi1);
      ph = seq[i];
      e  = expect_vec(ph, t, exp_ahi);
      o  = obs_vec();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL bus_phase t=%0d addr=%h phase=%0d: got %h expected %h", t, a, ph, o, e);
      end
      if ((ph == PH_T1) || (!t_read(t) && (ph != PH_T4))) begin
        total++;
        if (ad_out !== ((ph == PH_T1) ? a[7:0] : w)) begin
          bad++;
          $display("FAIL ad_out t=%0d phase=%0d: got %h expected %h", t, ph,
                   ad_out, (ph == PH_T1) ? a[7:0] : w);
        end
      end
      p_done = 0; p_rv = 0; p_to = 0;
      cyc_start = 1'b0;
      cyc_type  = 3'($urandom_range(0, 7));
      cyc_addr  = 16'($urandom);
      cyc_wdata = 8'($urandom);
      ad_in     = 8'($urandom);
      ready     = 1'($urandom_range(0, 1));
      if (ph == PH_TW) tws++;
      if ((ph == PH_T2) || (ph == PH_TW)) ready = (tws < z) ? 1'b0 : 1'b1;
      if (ph == PH_T3) begin
        ad_in = din;
        if (t != 0) begin p_done = 1; p_to = to; end
        if (t_read(t)) begin p_rv = 1; exp_rdata = din; end
      end
      if (ph == PH_T4) begin p_done = 1; p_to = to; end
      if ((i == seq.size() - 1) && chain) issue(nt, na, nw);
    end
  endtask

  // Idle cycles with reserved-type requests thrown at the controller.
  task automatic idle_cycles(input int n);
    logic [26:0] e, o;
    for (int i = 0; i < n; i++) begin
      @(negedge phi1);
      e = expect_vec(PH_IDLE, 0, exp_ahi);
      o = obs_vec();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL idle: got %h expected %h", o, e);
      end
      total++;
      if (ad_oe !== 1'b0) begin
        bad++;
        $display("FAIL idle_ad_oe: got %b expected 0", ad_oe);
      end
      p_done = 0; p_rv = 0; p_to = 0;
      cyc_start = 1'($urandom_range(0, 1));
      cyc_type  = 3'($urandom_range(5, 7));
      cyc_addr  = 16'($urandom);
      ready     = 1'($urandom_range(0, 1));
      ad_in     = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [26:0] e;
    rst = 1'b1;
    repeat (3) @(posedge phi1);
    @(negedge phi1);
    exp_ahi = 8'h00; exp_rdata = 8'h00;
    e = expect_vec(PH_IDLE, 0, 8'h00);
    total++;
    if (obs_vec() !== e) begin
      bad++;
      $display("FAIL reset_state: got %h expected %h", obs_vec(), e);
    end
    total++;
    if (ad_out !== 8'h00) begin
      bad++;
      $display("FAIL reset_ad_out: got %h expected 00", ad_out);
    end
    rst = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_memrd();
    issue(1, 16'h0100, 8'h00);
    run_txn(1, 16'h0100, 8'h00, 8'h3E, 0, 0, 0, 16'h0, 8'h0);
    idle_cycles(2);
  endtask

  task automatic test_memwr_waits();
    issue(2, 16'h2050, 8'hA5);
    run_txn(2, 16'h2050, 8'hA5, 8'h00, 2, 0, 0, 16'h0, 8'h0);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    issue(3, 16'h0042, 8'h00);
    run_txn(3, 16'h0042, 8'h00, 8'h5A, 0, 1, 0, 16'h1234, 8'h00);
    run_txn(0, 16'h1234, 8'h00, 8'hC3, 1, 0, 0, 16'h0, 8'h0);
    idle_cycles(2);
  endtask

  task automatic test_timeout();
    issue(1, 16'h8001, 8'h00);
    run_txn(1, 16'h8001, 8'h00, 8'h77, 8, 0, 0, 16'h0, 8'h0);
    idle_cycles(1);
    issue(4, 16'h00F0, 8'h19);
    run_txn(4, 16'h00F0, 8'h19, 8'h00, 3, 0, 0, 16'h0, 8'h0);
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    logic [26:0] e;
    issue(1, 16'h3344, 8'h00);
    @(negedge phi1);
    total++;
    if (ale !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_t1_ale: got %b expected 1", ale);
    end
    cyc_start = 1'b0; ready = 1'b0;
    @(negedge phi1);
    ready = 1'b0;
    @(negedge phi1);
    total++;
    if (rd_n !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_tw_rd_n: got %b expected 0", rd_n);
    end
    rst = 1'b1; ad_in = 8'hEE;
    @(negedge phi1);
    exp_ahi = 8'h00; exp_rdata = 8'h00;
    e = expect_vec(PH_IDLE, 0, 8'h00);
    total++;
    if (obs_vec() !== e) begin
      bad++;
      $display("FAIL rstmid_state: got %h expected %h", obs_vec(), e);
    end
    rst = 1'b0; ready = 1'b1;
    cyc_start = 1'b1; cyc_type = 3'd5; cyc_addr = 16'hBEEF;
    @(negedge phi1);
    total++;
    if (obs_vec() !== e) begin
      bad++;
      $display("FAIL reserved_type: got %h expected %h", obs_vec(), e);
    end
    cyc_start = 1'b0;
    idle_cycles(2);
  endtask

`ifdef BUS_HOLD_EN
  task automatic test_hold();
    hold = 1'b1;
    issue(1, 16'h5566, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(negedge phi1);
      total++;
      if ({hlda, bus_oe, cyc_rdy, ad_oe, rd_n, wr_n, ale} !== 7'b1000110) begin
        bad++;
        $display("FAIL hold_state: got %b expected 1000110",
                 {hlda, bus_oe, cyc_rdy, ad_oe, rd_n, wr_n, ale});
      end
    end
    hold = 1'b0;
    @(negedge phi1);
    total++;
    if ({hlda, bus_oe, cyc_rdy, ale} !== 4'b0110) begin
      bad++;
      $display("FAIL hold_release: got %b expected 0110", {hlda, bus_oe, cyc_rdy, ale});
    end
    run_txn(1, 16'h5566, 8'h00, 8'h9D, 0, 0, 0, 16'h0, 8'h0);
    idle_cycles(2);
  endtask
`endif

  task automatic test_random();
    int          t, nt, z;
    logic [15:0] a, na;
    logic [7:0]  w, nw;
    bit          chain;
    t = $urandom_range(0, 4); a = 16'($urandom); w = 8'($urandom);
    issue(t, a, w);
    for (int n = 0; n < 40; n++) begin
      nt = $urandom_range(0, 4); na = 16'($urandom); nw = 8'($urandom);
      z  = $urandom_range(0, 5);
      chain = (n != 39) && ($urandom_range(0, 1) == 1);
      run_txn(t, a, w, 8'($urandom), z, chain, nt, na, nw);
      if (!chain) begin
        idle_cycles($urandom_range(1, 2));
        if (n != 39) issue(nt, na, nw);
      end
      t = nt; a = na; w = nw;
    end
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_memrd();
    test_memwr_waits();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
`ifdef BUS_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bus_cycle_ctrl
`default_nettype wire
